cic_decim_mc: RTL

Multi-channel, parametrised-order CIC decimator for the DFE receive chain. Accepts a time-interleaved sample stream tagged with a channel index and keeps independent integrator, comb and phase-counter state per channel. Decimates each channel by a runtime-selectable power of two, removes the CIC gain by an exact shift, rounds and saturates. Sits between the front-end sample mux and the per-channel compensation FIR, replacing single-channel CIC instances.

---
 rtl/cic_decim_mc.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/cic_decim_mc.sv
// cic_decim_mc: time-interleaved multi-channel CIC decimator with per-channel integrator,
// comb and phase state. Define CIC_MC_BYPASS_EN to add a "bypass" port that sends samples straight out.
module cic_decim_mc #(
  parameter int DATA_WIDTH   = 16,
  parameter int DATA_FRAC    = 15,
  parameter int Q            = 3,
  parameter int N            = 1,
  parameter int CH           = 4,
  parameter int MAX_DEC_LOG2 = 4,
  localparam int LOG2_N      = (N == 2) ? 1 : 0,
  localparam int ACC_WIDTH   = DATA_WIDTH + Q * (MAX_DEC_LOG2 + LOG2_N),
  localparam int CH_W        = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_load,
  input  logic [2:0]            dec_log2,
  input  logic                  s_valid,
  input  logic [CH_W-1:0]       s_ch,
  input  logic [DATA_WIDTH-1:0] s_data,
`ifdef CIC_MC_BYPASS_EN
  input  logic                  bypass,
`endif
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CH_W-1:0]       m_ch,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  sat_flag,
  output logic                  ovr_flag,
  input  logic                  flag_clr
);

  localparam int PH_W = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  typedef logic signed [ACC_WIDTH:0]   rnd_t;

  localparam rnd_t SAT_MAX = {{(ACC_WIDTH - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam rnd_t SAT_MIN = {{(ACC_WIDTH - DATA_WIDTH + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  if (Q < 1 || Q > 6) begin : g_chk_q
    $error("cic_decim_mc: Q must be in 1..6");
  end
  if (N < 1 || N > 2) begin : g_chk_n
    $error("cic_decim_mc: N must be 1 or 2");
  end
  if (CH < 1 || CH > 16) begin : g_chk_ch
    $error("cic_decim_mc: CH must be in 1..16");
  end
  if (MAX_DEC_LOG2 < 0 || MAX_DEC_LOG2 > 7) begin : g_chk_dec
    $error("cic_decim_mc: MAX_DEC_LOG2 must be in 0..7");
  end
  if (DATA_FRAC < 0 || DATA_FRAC >= DATA_WIDTH) begin : g_chk_frac
    $error("cic_decim_mc: DATA_FRAC must be below DATA_WIDTH");
  end

  logic [2:0]      dec_q;
  logic [2:0]      dec_clamped;
  logic [PH_W-1:0] r_mask;

  acc_t            integ     [CH][Q];
  acc_t            integ_nxt [Q];
  acc_t            int_sum;
  acc_t            x_ext;
  logic [PH_W-1:0] phase     [CH];
  logic            acc_ok;
  logic            byp_ok;
  logic            dec_inst;

  // st_* index 0 is the integrator output register, index k+1 the output of comb stage k
  logic            st_vld  [Q+1];
  logic [CH_W-1:0] st_ch   [Q+1];
  acc_t            st_data [Q+1];
  acc_t            dly     [Q][CH][N];
  acc_t            comb_y  [Q];

  int              shift_amt;
  rnd_t            rnd_v;
  rnd_t            shifted;
  logic [DATA_WIDTH-1:0] res_data;
  logic            res_sat;

  logic            due;
  logic [CH_W-1:0] cand_ch;
  logic [DATA_WIDTH-1:0] cand_data;
  logic            cand_sat;
  logic            out_load;
  logic            set_ovr;
  logic            set_sat;

  always_comb begin
    dec_clamped = (dec_log2 > 3'(MAX_DEC_LOG2)) ? 3'(MAX_DEC_LOG2) : dec_log2;
    r_mask      = PH_W'((32'd1 << dec_q) - 32'd1);
  end

  // Samples arriving with cfg_load are discarded; out-of-range channels are ignored.
  always_comb begin
    acc_ok = s_valid && !cfg_load && (32'(s_ch) < 32'(CH));
    byp_ok = 1'b0;
`ifdef CIC_MC_BYPASS_EN
    byp_ok = acc_ok && bypass;
    acc_ok = acc_ok && !bypass;
`endif
  end

  always_comb begin
    x_ext   = {{(ACC_WIDTH - DATA_WIDTH){s_data[DATA_WIDTH-1]}}, s_data};
    int_sum = x_ext;
    for (int j = 0; j < Q; j++) begin
      integ_nxt[j] = integ[s_ch][j] + int_sum;
      int_sum      = integ_nxt[j];
    end
    dec_inst = (phase[s_ch] == '0);
  end

  always_comb begin
    for (int k = 0; k < Q; k++) begin
      comb_y[k] = st_data[k] - dly[k][st_ch[k]][N-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q <= '0;
    end else if (cfg_load) begin
      dec_q <= dec_clamped;
    end
  end

  // Integrators wrap freely; the comb differences recover the exact result modulo 2^ACC_WIDTH.
  always_ff @(posedge clk) begin
    if (rst || cfg_load) begin
      for (int c = 0; c < CH; c++) begin
        phase[c] <= '0;
        for (int j = 0; j < Q; j++) begin
          integ[c][j] <= '0;
        end
        for (int k = 0; k < Q; k++) begin
          for (int i = 0; i < N; i++) begin
            dly[k][c][i] <= '0;
          end
        end
      end
      for (int k = 0; k <= Q; k++) begin
        st_vld[k]  <= 1'b0;
        st_ch[k]   <= '0;
        st_data[k] <= '0;
      end
    end else begin
      if (acc_ok) begin
        for (int j = 0; j < Q; j++) begin
          integ[s_ch][j] <= integ_nxt[j];
        end
        phase[s_ch] <= (phase[s_ch] + PH_W'(1)) & r_mask;
      end
      st_vld[0]  <= acc_ok && dec_inst;
      st_ch[0]   <= s_ch;
      st_data[0] <= integ_nxt[Q-1];
      for (int k = 0; k < Q; k++) begin
        st_vld[k+1]  <= st_vld[k];
        st_ch[k+1]   <= st_ch[k];
        st_data[k+1] <= comb_y[k];
        if (st_vld[k]) begin
          dly[k][st_ch[k]][0] <= st_data[k];
          for (int i = 1; i < N; i++) begin
            dly[k][st_ch[k]][i] <= dly[k][st_ch[k]][i-1];
          end
        end
      end
    end
  end

  // One guard bit above the accumulator keeps the round-half-up addition from wrapping.
  always_comb begin
    shift_amt = Q * (int'(dec_q) + LOG2_N);
    rnd_v     = {st_data[Q][ACC_WIDTH-1], st_data[Q]};
    if (shift_amt > 0) begin
      rnd_v = rnd_v + (rnd_t'(1) <<< (shift_amt - 1));
    end
    shifted = rnd_v >>> shift_amt;
    res_sat = 1'b0;
    if (shifted > SAT_MAX) begin
      res_data = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
      res_sat  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      res_data = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
      res_sat  = 1'b1;
    end else begin
      res_data = shifted[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    due       = st_vld[Q] && !cfg_load;
    cand_ch   = st_ch[Q];
    cand_data = res_data;
    cand_sat  = res_sat;
    if (byp_ok) begin
      due       = 1'b1;
      cand_ch   = s_ch;
      cand_data = s_data;
      cand_sat  = 1'b0;
    end
    out_load = due && (!m_valid || m_ready);
    set_ovr  = due && m_valid && !m_ready;
    set_sat  = out_load && cand_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_ch    <= '0;
      m_data  <= '0;
    end else if (cfg_load) begin
      m_valid <= 1'b0;
    end else if (out_load) begin
      m_valid <= 1'b1;
      m_ch    <= cand_ch;
      m_data  <= cand_data;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // A set event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
      ovr_flag <= 1'b0;
    end else begin
      sat_flag <= (sat_flag && !flag_clr) || set_sat;
      ovr_flag <= (ovr_flag && !flag_clr) || set_ovr;
    end
  end

endmodule
